// File: rtl/dac_smoothing_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dac_smoothing_filter: boxcar average of 2^LOG2_TAPS mixer samples into DAC |
// | Optional FILTER_ROUND_EN: round-half-up with saturation.  Revision: 1.0    |
// +----------------------------------------------------------------------------+
module dac_smoothing_filter #(
  parameter int DATA_W    = 8,
  parameter int LOG2_TAPS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              filter_on,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sample,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sample,
  output logic              primed
);

  localparam int c_taps  = 1 << LOG2_TAPS;
  localparam int c_sum_w = DATA_W + LOG2_TAPS;
  localparam logic [DATA_W-1:0]  c_mid       = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [LOG2_TAPS:0] c_fill_full = {1'b1, {LOG2_TAPS{1'b0}}};

  typedef enum logic [1:0] {
    ST_BYPASS = 2'd0,
    ST_FILL   = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [LOG2_TAPS-1:0]   wptr_q, wptr_d;
  logic [LOG2_TAPS:0]     fill_cnt_q, fill_cnt_d;
  logic [c_sum_w-1:0]     sum_q, sum_d;
  logic [DATA_W-1:0]      smp_buf_q [c_taps];
  logic [DATA_W-1:0]      smp_buf_d [c_taps];
  logic [DATA_W-1:0]      out_sample_q, out_sample_d;
  logic                   out_valid_q, out_valid_d;

  logic [c_sum_w-1:0]     w_in_ext;
  logic [c_sum_w-1:0]     w_old_ext;
  logic [c_sum_w-1:0]     w_sum_next;
  logic [DATA_W-1:0]      w_avg;

  assign w_in_ext   = {{LOG2_TAPS{1'b0}}, in_sample};
  assign w_old_ext  = {{LOG2_TAPS{1'b0}}, smp_buf_q[wptr_q]};
  // The evicted sample is part of sum_q, so this subtraction never underflows.
  assign w_sum_next = sum_q + w_in_ext - w_old_ext;

`ifdef FILTER_ROUND_EN
  localparam logic [c_sum_w:0] c_half = {{c_sum_w{1'b0}}, 1'b1} << (LOG2_TAPS - 1);
  logic [c_sum_w:0] w_rnd_sum;
  logic [c_sum_w:0] w_rnd_shift;
  assign w_rnd_sum   = {1'b0, w_sum_next} + c_half;
  assign w_rnd_shift = w_rnd_sum >> LOG2_TAPS;
  assign w_avg       = (w_rnd_shift[c_sum_w:DATA_W] != '0) ? {DATA_W{1'b1}}
                                                           : w_rnd_shift[DATA_W-1:0];
`else
  assign w_avg = w_sum_next[c_sum_w-1:LOG2_TAPS];
`endif

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    fill_cnt_d   = fill_cnt_q;
    sum_d        = sum_q;
    smp_buf_d    = smp_buf_q;
    out_sample_d = out_sample_q;
    out_valid_d  = in_valid;

    if (!filter_on) begin
      state_d    = ST_BYPASS;
      wptr_d     = '0;
      fill_cnt_d = '0;
      sum_d      = '0;
      smp_buf_d  = '{default: '0};
      if (in_valid) out_sample_d = in_sample;
    end else begin
      case (state_q)
        ST_BYPASS: begin
          state_d = ST_FILL;
          if (in_valid) out_sample_d = in_sample;
        end
        ST_FILL: begin
          if (in_valid) begin
            smp_buf_d[wptr_q] = in_sample;
            sum_d             = sum_q + w_in_ext;
            wptr_d            = wptr_q + 1'b1;
            fill_cnt_d        = fill_cnt_q + 1'b1;
            out_sample_d      = in_sample;
            if (fill_cnt_d == c_fill_full) state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            smp_buf_d[wptr_q] = in_sample;
            sum_d             = w_sum_next;
            wptr_d            = wptr_q + 1'b1;
            out_sample_d      = w_avg;
          end
        end
        default: state_d = ST_BYPASS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_BYPASS;
      wptr_q       <= '0;
      fill_cnt_q   <= '0;
      sum_q        <= '0;
      smp_buf_q    <= '{default: '0};
      out_sample_q <= c_mid;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      fill_cnt_q   <= fill_cnt_d;
      sum_q        <= sum_d;
      smp_buf_q    <= smp_buf_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;
  assign primed     = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_dac_smoothing_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dac_smoothing_filter: directed + random stimulus against a queue model  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dac_smoothing_filter;

  localparam int DW = 8;
  localparam int LT = 2;
  localparam int NT = 1 << LT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          filter_on;
  logic          in_valid;
  logic [DW-1:0] in_sample;
  logic          out_valid;
  logic [DW-1:0] out_sample;
  logic          primed;

  int errors = 0;
  int checks = 0;

  // Reference: history of samples the filter currently averages, plus mode.
  int hist[$];
  int m_mode;      // 0 = off, 1 = collecting, 2 = averaging
  int m_out;
  int m_valid;

  dac_smoothing_filter #(.DATA_W(DW), .LOG2_TAPS(LT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .filter_on  (filter_on),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .primed     (primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int average(input int h[$]);
    int s = 0;
    foreach (h[i]) s += h[i];
`ifdef FILTER_ROUND_EN
    s = (s + NT / 2) / NT;
    return (s > 255) ? 255 : s;
`else
    return s / NT;
`endif
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      hist.delete();
      m_mode  = 0;
      m_out   = 127;
      m_valid = 0;
      return;
    end
    m_valid = in_valid;
    if (!filter_on) begin
      hist.delete();
      m_mode = 0;
      if (in_valid) m_out = in_sample;
    end else if (m_mode == 0) begin
      m_mode = 1;
      if (in_valid) m_out = in_sample;
    end else if (in_valid) begin
      hist.push_back(int'(in_sample));
      if (m_mode == 1) begin
        m_out = in_sample;
        if (hist.size() == NT) m_mode = 2;
      end else begin
        void'(hist.pop_front());
        m_out = average(hist);
      end
    end
  endtask

  task automatic cycle(input logic fo, input logic v, input logic [DW-1:0] s);
    filter_on = fo;
    in_valid  = v;
    in_sample = s;
    @(posedge clk);
    model_step();
    #1;
    chk("model_valid",  out_valid,  m_valid);
    chk("model_sample", out_sample, m_out);
    chk("model_primed", primed,     (m_mode == 2));
  endtask

  task automatic prime(input logic [DW-1:0] s);
    cycle(1'b0, 1'b0, 8'd0);
    cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < NT; i++) cycle(1'b1, 1'b1, s);
    chk("prime_primed", primed, 1);
  endtask

  initial begin
    rst_n = 1'b0; filter_on = 1'b0; in_valid = 1'b0; in_sample = '0;
    hist.delete(); m_mode = 0; m_out = 127; m_valid = 0;

    // Reset and idle hold
    cycle(1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 8'd55);
    chk("rst_sample", out_sample, 127);
    chk("rst_valid",  out_valid,  0);
    chk("rst_primed", primed,     0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 8'd9);
    cycle(1'b0, 1'b0, 8'd9);
    chk("idle_sample", out_sample, 127);
    chk("idle_valid",  out_valid,  0);

    // Passthrough
    cycle(1'b0, 1'b1, 8'd10);
    chk("pass_10", out_sample, 10);
    chk("pass_v",  out_valid,  1);
    cycle(1'b0, 1'b1, 8'd200);
    chk("pass_200", out_sample, 200);
    cycle(1'b0, 1'b0, 8'd0);
    chk("pass_vdrop", out_valid, 0);
    chk("pass_hold",  out_sample, 200);

    // Enter FILL with constant 100
    cycle(1'b1, 1'b1, 8'd100);
    chk("fill_entry", out_sample, 100);
    chk("fill_entry_p", primed, 0);
    for (int i = 0; i < NT; i++) begin
      cycle(1'b1, 1'b1, 8'd100);
      chk("fill_sample", out_sample, 100);
      chk("fill_primed", primed, (i == NT - 1));
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 8'd100);
      chk("run_const", out_sample, 100);
    end

    // Step response from zeros with a gap
    prime(8'd0);
    cycle(1'b1, 1'b1, 8'd200); chk("step_50",  out_sample, 50);
    cycle(1'b1, 1'b1, 8'd200); chk("step_100", out_sample, 100);
    cycle(1'b1, 1'b0, 8'd17);  chk("step_hold", out_sample, 100);
    chk("step_gapv", out_valid, 0);
    cycle(1'b1, 1'b1, 8'd200); chk("step_150", out_sample, 150);
    cycle(1'b1, 1'b1, 8'd200); chk("step_200", out_sample, 200);
    cycle(1'b1, 1'b1, 8'd200); chk("step_200b", out_sample, 200);

    // Truncation / rounding boundary, and full-scale
    prime(8'd0);
    cycle(1'b1, 1'b1, 8'd1); chk("lsb_1", out_sample, 0);
    cycle(1'b1, 1'b1, 8'd2);
`ifdef FILTER_ROUND_EN
    chk("lsb_2", out_sample, 1);
`else
    chk("lsb_2", out_sample, 0);
`endif
    prime(8'd255);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 8'd255);
      chk("full_scale", out_sample, 255);
    end

    // Leave RUN, restart FILL, reset mid-RUN
    cycle(1'b0, 1'b1, 8'd37);
    chk("drop_37", out_sample, 37);
    chk("drop_primed", primed, 0);
    cycle(1'b1, 1'b1, 8'd5);
    chk("refill_entry", out_sample, 5);
    for (int i = 0; i < NT; i++) begin
      cycle(1'b1, 1'b1, 8'(20 * (i + 1)));
      chk("refill_primed", primed, (i == NT - 1));
    end
    cycle(1'b1, 1'b1, 8'd100);
    chk("refill_avg", out_sample, (40 + 60 + 80 + 100) / NT);
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, 8'd99);
    chk("mid_rst_sample", out_sample, 127);
    chk("mid_rst_valid",  out_valid,  0);
    chk("mid_rst_primed", primed,     0);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic          fo, v;
      logic [DW-1:0] s;
      fo = ($urandom_range(0, 24) != 0);
      v  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       s = 8'd0;
        1:       s = 8'd255;
        default: s = 8'($urandom);
      endcase
      rst_n = ($urandom_range(0, 149) != 0);
      cycle(fo, v, s);
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_smoothing_filter.md
Name: dac_smoothing_filter

Overview:
- Output stage directly downstream of the dual-NCO mixer; consumes its offset-binary product (midscale 127) and drives the R2R DAC pins.
- Boxcar (moving-average) filter over 2^LOG2_TAPS samples, selected by the filter_on control bit; passthrough when off.
- Ring buffer + running sum; fill/prime state machine so the output never ramps up from zero.

Parameters:
DATA_W, 8, sample width, unsigned offset-binary
LOG2_TAPS, 2, log2 of averaging length N; legal range 1..4

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
filter_on  in  1  1 = average, 0 = passthrough; sampled every cycle
in_valid  in  1  in_sample is accepted this cycle
in_sample  in  DATA_W  mixer output sample, unsigned
out_valid  out  1  out_sample updated this cycle
out_sample  out  DATA_W  filtered or passthrough sample to DAC
primed  out  1  high while in RUN (buffer holds N valid samples)

Behaviour:
- Reset: synchronous, active-low; reset rst_n; clock clk. Reset values: out_sample = 127, out_valid = 0, primed = 0, state = BYPASS, wptr = 0, fill_cnt = 0, sum = 0, all buffer entries = 0.
- Storage: buf[0..N-1] of DATA_W bits; wptr of LOG2_TAPS bits, wraps N-1 -> 0; sum of DATA_W+LOG2_TAPS bits, which cannot overflow; fill_cnt of LOG2_TAPS+1 bits.
- States:
  - BYPASS: filter off.
  - FILL: collecting the first N samples.
  - RUN: averaging.
- filter_on = 0 has priority in every state:
  - Next state = BYPASS.
  - sum, wptr and fill_cnt are cleared and all buf entries zeroed on that edge.
  - A sample accepted that cycle is passed through.
- BYPASS -> FILL on the first edge with filter_on = 1. No sample is written on that edge; an accepted sample is passed through.
- FILL, accepted sample:
  - buf[wptr] <= in_sample; sum <= sum + in_sample; wptr++; fill_cnt++.
  - out_sample <= in_sample (passthrough).
  - When fill_cnt reaches N on this edge -> RUN; primed = 1 from the next cycle.
- RUN, accepted sample:
  - sum_next = sum + in_sample - buf[wptr]; buf[wptr] <= in_sample; wptr++.
  - out_sample <= sum_next >> LOG2_TAPS (truncation unless FILTER_ROUND_EN).
- Latency: 1 cycle. out_valid <= in_valid registered; out_sample changes only on accepted samples and holds its value otherwise.
- in_valid = 0: no state, pointer, sum or buffer change (except clearing forced by filter_on = 0).
- primed = (state == RUN). It deasserts on the edge that leaves RUN.
- Reset mid-FILL or mid-RUN: all values return to their reset values on that edge; the in-flight sample is discarded and out_valid = 0 next cycle.
- Output is always within 0..2^DATA_W-1; no clipping is needed.

Optional Feature:
- Macro: FILTER_ROUND_EN.
- Defined: RUN output = (sum_next + 2^(LOG2_TAPS-1)) >> LOG2_TAPS (round-half-up). The sum is widened by 1 bit internally and the result is saturated to 2^DATA_W-1.
- Undefined: plain truncation; no extra adder.
- FILL and BYPASS are unaffected either way.

Test Plan:
1. Assert rst_n = 0 for 2 cycles -> out_sample = 127, out_valid = 0, primed = 0. Hold in_valid = 0 after release -> outputs unchanged.
2. filter_on = 0, in_valid = 1, feed 10 then 200 -> out_sample = 10, then 200, each 1 cycle later; out_valid follows in_valid with 1-cycle delay.
3. LOG2_TAPS = 2, raise filter_on, feed constant 100:
   - Edge that enters FILL: out_sample = 100 (passthrough, no buffer write).
   - Next 4 samples: out_sample = 100 (passthrough, buffer filling); primed = 1 after the 4th.
   - Further samples: out_sample = 100.
4. Primed on four 0s, then feed 200 repeatedly -> out_sample = 50, 100, 150, 200, 200.
   - Insert an in_valid = 0 cycle between the 2nd and 3rd sample: output holds 100 and the sequence continues unchanged.
5. Primed on four 0s, feed 1 then 2 -> truncating build: 0, 0; FILTER_ROUND_EN build: 0, 1. Primed on 255s -> output 255 in both builds (no overflow).
6. Mid-RUN:
   - Drop filter_on with input 37 -> out_sample = 37 next cycle; primed = 0.
   - Re-raise filter_on -> FILL restarts with a cleared buffer; primed = 1 only after 4 more accepted samples.
   - Pulse rst_n low mid-RUN -> reset values next cycle.
